// File: rtl/expstate_arb_pkg.sv
// Shared types and constants for the export-state to import-wire arbiter.
// Holds the FSM state encoding, parameter defaults and the index-width helper.
package expstate_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_SRC     = 32'd4;
    localparam int unsigned DEF_WIDTH       = 32'd32;
    localparam int unsigned DEF_HOLD_CYCLES = 32'd4;
    localparam int unsigned DEF_CNT_W       = 32'd8;

    // Ceiling log2: number of bits needed to index n items.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 32'd0;
        while ((32'd1 << r) < n) begin
            r = r + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/expstate_wire_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after the
// pointer wins, searching upward and wrapping.
module rr_arbiter
    import expstate_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
    localparam int unsigned IDX_W   = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int             cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic           hit_s;

    // Walk the ring once starting just past the pointer; first hit wins.
    always_comb begin
        gnt_o      = '0;
        idx_o      = '0;
        any_o      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        hit_s      = 1'b0;
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            cand_s              = (int'(ptr_i) + k) % int'(NUM_SRC);
            cand_idx_s          = cand_s[IDX_W-1:0];
            hit_s               = req_i[cand_idx_s] & ~any_o;
            gnt_o[cand_idx_s]   = gnt_o[cand_idx_s] | hit_s;
            idx_o               = hit_s ? cand_idx_s : idx_o;
            any_o               = any_o | hit_s;
        end
    end

endmodule

// File: rtl/expstate_wire_arbiter.sv
// Forwards changed producer export states onto one consumer import wire,
// round-robin, holding each forwarded value stable for HOLD_CYCLES cycles.
module expstate_wire_arbiter
    import expstate_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC     = DEF_NUM_SRC,
    parameter  int unsigned WIDTH       = DEF_WIDTH,
    parameter  int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter  int unsigned CNT_W       = DEF_CNT_W,
    localparam int unsigned IDX_W       = clog2(NUM_SRC)
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [NUM_SRC*WIDTH-1:0] EXPSTATE_IN,
    input  logic [NUM_SRC-1:0]       SRC_ENABLE,
    output logic [WIDTH-1:0]         IMPWIRE_OUT,
    output logic [IDX_W-1:0]         IMPWIRE_SRC,
    output logic                     UPDATE,
    output logic                     BUSY,
    output logic [CNT_W-1:0]         OVERWRITE_CNT
);

    localparam int unsigned HCNT_W = clog2(HOLD_CYCLES + 32'd1);

    logic [WIDTH-1:0]   last_seen_q [NUM_SRC];
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    arb_state_e         state_q, state_d;
    logic [HCNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]   impwire_q, impwire_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic               update_q, update_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   ovw_cnt_q, ovw_cnt_d;

    logic [NUM_SRC-1:0] chg_s;
    logic [NUM_SRC-1:0] ovw_s;
    logic [NUM_SRC-1:0] gnt_s;
    logic [IDX_W-1:0]   sel_s;
    logic               any_s;
    logic               grant_s;

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_chg
        assign chg_s[g] = SRC_ENABLE[g] && (EXPSTATE_IN[g*WIDTH +: WIDTH] != last_seen_q[g]);
    end

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_s),
        .idx_o   (sel_s),
        .any_o   (any_s)
    );

    assign grant_s = (state_q == ST_IDLE) && any_s;

    // Pending bookkeeping: disable clears, a change in the grant cycle re-arms
    // the granted source, and a change on an already-pending source is lost.
    always_comb begin
        pending_d = '0;
        ovw_s     = '0;
        ovw_cnt_d = ovw_cnt_q;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            ovw_s[i] = chg_s[i] & pending_q[i] & ~(grant_s & gnt_s[i]);
            if (!SRC_ENABLE[i]) begin
                pending_d[i] = 1'b0;
            end else if (grant_s && gnt_s[i]) begin
                pending_d[i] = chg_s[i];
            end else begin
                pending_d[i] = pending_q[i] | chg_s[i];
            end
            ovw_cnt_d = (ovw_s[i] && (ovw_cnt_d != {CNT_W{1'b1}}))
                        ? ovw_cnt_d + CNT_W'(1'b1) : ovw_cnt_d;
        end
    end

    // Grant / hold state machine and output next-state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        impwire_d  = impwire_q;
        src_d      = src_q;
        update_d   = 1'b0;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    impwire_d  = EXPSTATE_IN[int'(sel_s)*WIDTH +: WIDTH];
                    src_d      = sel_s;
                    update_d   = 1'b1;
                    busy_d     = 1'b1;
                    ptr_d      = sel_s;
                    hold_cnt_d = HCNT_W'(HOLD_CYCLES - 32'd1);
                    state_d    = ST_HOLD;
                end else begin
                    busy_d     = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HCNT_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Last-seen sampling runs every cycle regardless of enable, so enabling a
    // source never reports a stale difference.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                last_seen_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                last_seen_q[i] <= EXPSTATE_IN[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control and output registers; pointer resets to the last source so that
    // source 0 has first priority.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q  <= '0;
            ptr_q      <= IDX_W'(NUM_SRC - 32'd1);
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            impwire_q  <= '0;
            src_q      <= '0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
            ovw_cnt_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            impwire_q  <= impwire_d;
            src_q      <= src_d;
            update_q   <= update_d;
            busy_q     <= busy_d;
            ovw_cnt_q  <= ovw_cnt_d;
        end
    end

    assign IMPWIRE_OUT   = impwire_q;
    assign IMPWIRE_SRC   = src_q;
    assign UPDATE        = update_q;
    assign BUSY          = busy_q;
    assign OVERWRITE_CNT = ovw_cnt_q;

endmodule

// File: tb/tb_expstate_wire_arbiter.sv
// Self-checking bench for expstate_wire_arbiter: directed table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_expstate_wire_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int HOLD = 4;
    localparam int CNTW = 8;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [N*W-1:0]   EXPSTATE_IN;
    logic [N-1:0]     SRC_ENABLE;
    logic [W-1:0]     IMPWIRE_OUT;
    logic [1:0]       IMPWIRE_SRC;
    logic             UPDATE;
    logic             BUSY;
    logic [CNTW-1:0]  OVERWRITE_CNT;

    logic [W-1:0] vals [N];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < N; i++) EXPSTATE_IN[i*W +: W] = vals[i];
    end

    expstate_wire_arbiter #(
        .NUM_SRC(N), .WIDTH(W), .HOLD_CYCLES(HOLD), .CNT_W(CNTW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .EXPSTATE_IN(EXPSTATE_IN),
        .SRC_ENABLE(SRC_ENABLE), .IMPWIRE_OUT(IMPWIRE_OUT),
        .IMPWIRE_SRC(IMPWIRE_SRC), .UPDATE(UPDATE), .BUSY(BUSY),
        .OVERWRITE_CNT(OVERWRITE_CNT)
    );

    // Behavioural model: m_hold counts edges left until the wire is free again.
    logic [W-1:0] m_last [N];
    bit           m_pend [N];
    int           m_ptr, m_hold, m_src, m_cnt;
    logic [W-1:0] m_out;
    bit           m_upd, m_busy;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_last[i] = '0; m_pend[i] = 0; end
        m_ptr = N - 1; m_hold = 0; m_src = 0; m_cnt = 0;
        m_out = '0; m_upd = 0; m_busy = 0;
    endtask

    task automatic model_edge();
        bit chg [N];
        int g;
        g = -1;
        for (int i = 0; i < N; i++) chg[i] = SRC_ENABLE[i] && (vals[i] !== m_last[i]);
        if (m_hold == 0) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (chg[i] && m_pend[i] && i != g && m_cnt < (1 << CNTW) - 1) m_cnt++;
            if (!SRC_ENABLE[i]) m_pend[i] = 0;
            else if (i == g)    m_pend[i] = chg[i];
            else                m_pend[i] = m_pend[i] || chg[i];
            m_last[i] = vals[i];
        end
        if (g >= 0) begin
            m_out = vals[g]; m_src = g; m_upd = 1; m_busy = 1; m_ptr = g; m_hold = HOLD;
        end else begin
            m_upd = 0;
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_busy = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model();
        chk("m_update", 64'(UPDATE), 64'(m_upd));
        chk("m_busy",   64'(BUSY), 64'(m_busy));
        chk("m_out",    64'(IMPWIRE_OUT), 64'(m_out));
        chk("m_src",    64'(IMPWIRE_SRC), 64'(m_src));
        chk("m_ovwcnt", 64'(OVERWRITE_CNT), 64'(m_cnt));
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic wait_update(input int max_cyc, output bit seen);
        seen = 0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            step(); check_model();
            if (UPDATE) seen = 1;
        end
    endtask

    task automatic zero_vals();
        for (int i = 0; i < N; i++) vals[i] = '0;
    endtask

    typedef struct {
        logic [W-1:0] v0;
        logic [W-1:0] v2;
        bit           upd;
        bit           busy;
        logic [W-1:0] out;
        int           src;
    } vec_t;

    vec_t tbl [8];

    int   srcs [3];
    int   cycs [3];
    int   nseen, n3, n1;
    logic [W-1:0] last1;
    bit   seen;

    // Burst of simultaneous changes on sources 0, 1 and 3.
    task automatic burst(input logic [W-1:0] base);
        vals[0] = base + 32'd1; vals[1] = base + 32'd2; vals[3] = base + 32'd3;
        nseen = 0;
        for (int c = 0; c < 30; c++) begin
            step(); check_model();
            if (UPDATE) begin
                if (nseen < 3) begin srcs[nseen] = int'(IMPWIRE_SRC); cycs[nseen] = c; end
                nseen++;
            end
        end
        chk("burst_count", 64'(nseen), 64'd3);
        chk("burst_first", 64'(srcs[0]), 64'd0);
        chk("burst_second", 64'(srcs[1]), 64'd1);
        chk("burst_third", 64'(srcs[2]), 64'd3);
        chk("burst_gap1", 64'(cycs[1] - cycs[0]), 64'(HOLD + 1));
        chk("burst_gap2", 64'(cycs[2] - cycs[1]), 64'(HOLD + 1));
    endtask

    initial begin
        tbl[0] = '{32'h0,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        0};
        tbl[1] = '{32'h0,  32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 2};
        tbl[2] = '{32'h0,  32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 2};
        tbl[3] = '{32'hA5, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 2};
        tbl[4] = '{32'hA5, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 2};
        tbl[5] = '{32'hA5, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 2};
        tbl[6] = '{32'hA5, 32'hDEADBEEF, 1'b1, 1'b1, 32'hA5,       0};
        tbl[7] = '{32'hA5, 32'hDEADBEEF, 1'b0, 1'b1, 32'hA5,       0};

        RESET_N = 1'b0;
        SRC_ENABLE = '1;
        zero_vals();
        do_reset();

        // Reset state and quiet idle period.
        chk("rst_out", 64'(IMPWIRE_OUT), 64'd0);
        chk("rst_src", 64'(IMPWIRE_SRC), 64'd0);
        chk("rst_update", 64'(UPDATE), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_ovwcnt", 64'(OVERWRITE_CNT), 64'd0);
        for (int c = 0; c < 20; c++) begin
            step(); check_model();
            chk("idle_update", 64'(UPDATE), 64'd0);
        end

        // Single change latency and hold window, second grant at t+7.
        for (int r = 0; r < 8; r++) begin
            vals[0] = tbl[r].v0; vals[2] = tbl[r].v2;
            step();
            chk($sformatf("tbl%0d_update", r), 64'(UPDATE), 64'(tbl[r].upd));
            chk($sformatf("tbl%0d_busy", r), 64'(BUSY), 64'(tbl[r].busy));
            chk($sformatf("tbl%0d_out", r), 64'(IMPWIRE_OUT), 64'(tbl[r].out));
            chk($sformatf("tbl%0d_src", r), 64'(IMPWIRE_SRC), 64'(tbl[r].src));
        end
        for (int c = 0; c < 8; c++) begin step(); check_model(); end

        // Round-robin bursts, twice so the pointer wraps past 3.
        zero_vals();
        do_reset();
        burst(32'h1000);
        burst(32'h2000);

        // Overwrites of source 1 while source 0 is held.
        zero_vals();
        do_reset();
        vals[0] = 32'h11;
        wait_update(10, seen);
        chk("ovw_first_grant", 64'(seen), 64'd1);
        for (int v = 1; v <= 3; v++) begin
            vals[1] = W'(v);
            step(); check_model();
        end
        n1 = 0; last1 = '0;
        for (int c = 0; c < 12; c++) begin
            step(); check_model();
            if (UPDATE && IMPWIRE_SRC == 2'd1) begin n1++; last1 = IMPWIRE_OUT; end
        end
        chk("ovw_count", 64'(OVERWRITE_CNT), 64'd2);
        chk("ovw_src1_updates", 64'(n1), 64'd1);
        chk("ovw_final_value", 64'(last1), 64'd3);

        // Disable while pending, re-enable unchanged, then a real change.
        zero_vals();
        do_reset();
        vals[0] = 32'h22;
        wait_update(10, seen);
        chk("dis_first_grant", 64'(seen), 64'd1);
        vals[3] = 32'h33;
        step(); check_model();
        SRC_ENABLE[3] = 1'b0;
        n3 = 0;
        for (int c = 0; c < 12; c++) begin
            step(); check_model();
            if (UPDATE && IMPWIRE_SRC == 2'd3) n3++;
        end
        chk("dis_no_grant3", 64'(n3), 64'd0);
        SRC_ENABLE[3] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(); check_model();
            if (UPDATE && IMPWIRE_SRC == 2'd3) n3++;
        end
        chk("reen_no_grant3", 64'(n3), 64'd0);
        vals[3] = 32'h34;
        for (int c = 0; c < 12; c++) begin
            step(); check_model();
            if (UPDATE && IMPWIRE_SRC == 2'd3) n3++;
        end
        chk("reen_change_grant3", 64'(n3), 64'd1);
        chk("reen_value", 64'(IMPWIRE_OUT), 64'h34);

        // Asynchronous reset in the middle of a hold with two sources pending.
        zero_vals();
        do_reset();
        vals[0] = 32'h55;
        wait_update(10, seen);
        chk("mid_first_grant", 64'(seen), 64'd1);
        vals[1] = 32'h7; vals[2] = 32'h9;
        step(); check_model();
        step(); check_model();
        #3;
        RESET_N = 1'b0;
        #1;
        chk("async_out", 64'(IMPWIRE_OUT), 64'd0);
        chk("async_update", 64'(UPDATE), 64'd0);
        chk("async_busy", 64'(BUSY), 64'd0);
        chk("async_src", 64'(IMPWIRE_SRC), 64'd0);
        model_reset();
        zero_vals();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step(); check_model();
            chk("post_rst_no_update", 64'(UPDATE), 64'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) vals[i] = $urandom;
                if ($urandom_range(0, 19) == 0) SRC_ENABLE[i] = ~SRC_ENABLE[i];
            end
            step(); check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/expstate_wire_arbiter.md
Name: expstate_wire_arbiter

Overview:
- Shares one consumer core's 32-bit TIE import wire between NUM_SRC producer cores, each driving a TIE export-state bus.
- Detects changes on each producer's export state and grants them round-robin.
- Drives the selected value onto the import wire and holds it stable for HOLD_CYCLES cycles so the consumer can sample it.
- Sits in the multi-core cosim top level, between the producers' TIE_EXPSTATE outputs and the consumer's TIE_IMPWIRE input.

Parameters:
- NUM_SRC, 4: number of producer cores; must be 2..16.
- WIDTH, 32: export-state / import-wire width.
- HOLD_CYCLES, 4: minimum cycles IMPWIRE_OUT stays stable after an update; must be ≥1.
- CNT_W, 8: width of the overwrite counter.

Ports:
- CLK, input, 1: single clock; all state is updated on the rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- EXPSTATE_IN, input, NUM_SRC*WIDTH: producer export states; source i occupies bits [i*WIDTH +: WIDTH].
- SRC_ENABLE, input, NUM_SRC: per-source enable; a disabled source is never granted.
- IMPWIRE_OUT, output, WIDTH: registered value driven to the consumer's import wire.
- IMPWIRE_SRC, output, clog2(NUM_SRC): index of the source currently on IMPWIRE_OUT.
- UPDATE, output, 1: one-cycle pulse in the first cycle a new value is on IMPWIRE_OUT.
- BUSY, output, 1: high while in the HOLD state.
- OVERWRITE_CNT, output, CNT_W: saturating count of changes that were lost before being forwarded.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - IMPWIRE_OUT=0, IMPWIRE_SRC=0, UPDATE=0, BUSY=0, OVERWRITE_CNT=0.
  - All last_seen[i]=0, all pending[i]=0, FSM=IDLE.
  - Round-robin pointer = NUM_SRC-1, so source 0 has first priority.
  - Reset during HOLD drops all pending work; no UPDATE follows reset.
- Change detection, every cycle, per source i:
  - last_seen[i] <= EXPSTATE_IN[i] unconditionally, including when disabled. Enabling a source therefore never causes a spurious change.
  - chg[i] = SRC_ENABLE[i] && (EXPSTATE_IN[i] != last_seen[i]).
  - chg[i] sets pending[i] at the next edge.
  - chg[i] while pending[i] is already 1 and not being granted this cycle: OVERWRITE_CNT += 1, saturating at all-ones.
  - SRC_ENABLE[i]=0 clears pending[i] at the next edge; this has priority over a set.
  - Non-zero export states present at reset release are reported as changes, because last_seen resets to 0.
- FSM, two states:
  - IDLE, with any pending[i] set:
    - Arbiter selects sel = first pending index strictly after the pointer, wrapping.
    - Next edge: IMPWIRE_OUT <= EXPSTATE_IN[sel] (live value at grant time); IMPWIRE_SRC <= sel; UPDATE <= 1; BUSY <= 1.
    - Same edge: pointer <= sel; pending[sel] <= chg[sel] (a change in the grant cycle re-arms without counting as an overwrite); hold counter <= HOLD_CYCLES-1; FSM <= HOLD.
  - IDLE, with nothing pending: outputs hold their values; UPDATE=0.
  - HOLD:
    - UPDATE=0 after its first cycle; the counter decrements.
    - Counter==0: FSM <= IDLE and BUSY <= 0.
    - IMPWIRE_OUT never changes in HOLD.
  - Timing:
    - Latency: input change at edge t is pending at t+1 and on IMPWIRE_OUT (with UPDATE=1) at t+2 when uncontended.
    - Minimum spacing between UPDATE pulses is HOLD_CYCLES+1 cycles.
  - Simultaneous changes on several sources are serviced in round-robin order, one grant per IDLE visit.
- Width rules:
  - Comparisons are full WIDTH.
  - IMPWIRE_SRC is zero-extended if clog2(NUM_SRC) exceeds the index width.

Decomposition:
- Shared package expstate_arb_pkg:
  - FSM state enum {ST_IDLE, ST_HOLD}.
  - Index-width function clog2.
  - Default parameter constants.
- Sub-module rr_arbiter: parameterised NUM_SRC; pending vector and pointer in, one-hot grant plus encoded index and any_req out; combinational.
- The pointer register stays in the parent.

Test Plan:
- Reset release with all inputs 0 → no UPDATE for 20 cycles; all outputs 0.
- Source 2 changes 0→0xDEADBEEF at edge t, HOLD_CYCLES=4 → UPDATE at t+2 with IMPWIRE_OUT=0xDEADBEEF and IMPWIRE_SRC=2; BUSY high for 4 cycles; next grant possible at t+7.
- Sources 0, 1 and 3 change in the same cycle → three UPDATEs, 5 cycles apart, in order 0, 1, 3; next simultaneous burst starts at source 0 after the pointer wraps past 3.
- Source 1 changes three times within one HOLD window while source 0 is being held → OVERWRITE_CNT=2; a single later UPDATE carries the final value.
- SRC_ENABLE[3]=0 while pending[3]=1 → no grant to 3. Re-enabling with an unchanged input gives no UPDATE; a new change gives an UPDATE.
- RESET_N pulsed low mid-HOLD with two sources pending → outputs 0 immediately; after release no UPDATE unless inputs differ from 0.
